// File: rtl/reg_file_alu_pkg.sv
// Shared types for the reg_file_alu instruction sequencer: instruction kinds,
// controller states, the default instruction layout and the ALU op codes.
package reg_file_alu_pkg;

  typedef enum logic [1:0] {
    K_NOP = 2'b00,
    K_LDI = 2'b01,
    K_ALU = 2'b10,
    K_RD  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 2 * DEF_ADDR_W;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Immediate for LDI occupies the ra1/ra2 fields together.
  typedef struct packed {
    kind_e                 kind;
    logic [1:0]            aluctl;
    logic [DEF_ADDR_W-1:0] wa;
    logic [DEF_ADDR_W-1:0] ra1;
    logic [DEF_ADDR_W-1:0] ra2;
  } instr_t;

  function automatic logic writesReg(input kind_e kind);
    return (kind == K_LDI) || (kind == K_ALU);
  endfunction

endpackage

// File: rtl/reg_file_alu_ctrl.sv
// Single-issue sequencer for the reg_file_alu datapath: accepts one instruction,
// drives the reg-file/ALU controls through the settle window, commits, returns the result.
module reg_file_alu_ctrl #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [4+3*ADDR_W-1:0]   instr,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic [ADDR_W-1:0]       res_wa,
  output logic                    busy,
  output logic [CNT_W-1:0]        retired_count,
  output logic [ADDR_W-1:0]       rf_RA1,
  output logic [ADDR_W-1:0]       rf_RA2,
  output logic [ADDR_W-1:0]       rf_WA,
  output logic [DATA_W-1:0]       rf_external_data_in,
  output logic                    rf_RegWrite,
  output logic                    rf_ALUSrc,
  output logic [1:0]              rf_ALUControl,
  input  logic [DATA_W-1:0]       rf_ALUResult
);
  import reg_file_alu_pkg::*;

  localparam int INSTR_W = 4 + 3 * ADDR_W;
  localparam int SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  generate
    if (SETTLE_CYCLES < 1) begin : g_badSettle
      $error("reg_file_alu_ctrl: SETTLE_CYCLES must be at least 1");
    end
    if (DATA_W != 2 * ADDR_W) begin : g_badWidth
      $error("reg_file_alu_ctrl: DATA_W must equal 2*ADDR_W");
    end
  endgenerate

  state_e               r_state;
  logic [INSTR_W-1:0]   r_instrQ;
  logic [SC_W-1:0]      r_settleCnt;
  logic [DATA_W-1:0]    r_resData;
  logic [ADDR_W-1:0]    r_resWa;
  logic [CNT_W-1:0]     r_retired;
  logic                 r_resValid;
  logic                 r_regWrite;

  kind_e                w_kind;
  kind_e                w_newKind;
  logic [1:0]           w_aluCtl;
  logic [ADDR_W-1:0]    w_wa;
  logic [ADDR_W-1:0]    w_ra1;
  logic [ADDR_W-1:0]    w_ra2;
  logic                 w_lastSettle;

  assign w_kind       = kind_e'(r_instrQ[INSTR_W-1 -: 2]);
  assign w_newKind    = kind_e'(instr[INSTR_W-1 -: 2]);
  assign w_aluCtl     = r_instrQ[INSTR_W-3 -: 2];
  assign w_wa         = r_instrQ[3*ADDR_W-1 -: ADDR_W];
  assign w_ra1        = r_instrQ[2*ADDR_W-1 -: ADDR_W];
  assign w_ra2        = r_instrQ[ADDR_W-1:0];
  assign w_lastSettle = (SETTLE_CYCLES == 1);

  // The write-enable is registered one cycle ahead so it is high exactly in the
  // final settle cycle, letting the reg file capture on the edge that leaves EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_instrQ    <= '0;
      r_settleCnt <= '0;
      r_resData   <= '0;
      r_resWa     <= '0;
      r_retired   <= '0;
      r_resValid  <= 1'b0;
      r_regWrite  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instrQ <= instr;
            if (w_newKind == K_NOP) begin
              r_retired <= r_retired + 1'b1;
            end else begin
              r_settleCnt <= SC_W'(SETTLE_CYCLES - 1);
              r_regWrite  <= w_lastSettle && writesReg(w_newKind);
              r_state     <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (r_settleCnt == '0) begin
            r_regWrite <= 1'b0;
            r_resData  <= rf_ALUResult;
            r_resWa    <= (w_kind == K_RD) ? w_ra1 : w_wa;
            r_resValid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_settleCnt <= r_settleCnt - 1'b1;
            r_regWrite  <= (r_settleCnt == SC_W'(1)) && writesReg(w_kind);
          end
        end
        S_RESP: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_retired  <= r_retired + 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_resValid <= 1'b0;
          r_regWrite <= 1'b0;
        end
      endcase
    end
  end

  // Datapath controls come straight from the latched instruction so they never glitch.
  assign rf_RA1              = w_ra1;
  assign rf_RA2              = w_ra2;
  assign rf_WA               = w_wa;
  assign rf_external_data_in = r_instrQ[DATA_W-1:0];
  assign rf_ALUSrc           = (w_kind == K_LDI);
  assign rf_ALUControl       = w_aluCtl;
  assign rf_RegWrite         = r_regWrite;

  assign instr_ready   = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign res_valid     = r_resValid;
  assign res_data      = r_resData;
  assign res_wa        = r_resWa;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_reg_file_alu_ctrl.sv
// Self-checking bench for reg_file_alu_ctrl: a behavioural reg file/ALU closes the
// loop, and a golden register array predicts every returned result and commit.
module tb_reg_file_alu_ctrl;
  import reg_file_alu_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int SETTLE = 3;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [15:0]       instr = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [7:0]        res_data;
  logic [3:0]        res_wa;
  logic              busy;
  logic [15:0]       retired_count;
  logic [3:0]        rf_RA1, rf_RA2, rf_WA;
  logic [7:0]        rf_external_data_in;
  logic              rf_RegWrite;
  logic              rf_ALUSrc;
  logic [1:0]        rf_ALUControl;
  logic [7:0]        rf_ALUResult;

  logic [7:0]        envRf [16] = '{default: 8'h00};
  logic [7:0]        envB;

  logic [7:0]        gold [16] = '{default: 8'h00};
  logic [15:0]       modelCount = '0;
  int                vectorCount = 0;
  int                miscompareCount = 0;

  reg_file_alu_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_wa(res_wa),
    .busy(busy), .retired_count(retired_count),
    .rf_RA1(rf_RA1), .rf_RA2(rf_RA2), .rf_WA(rf_WA),
    .rf_external_data_in(rf_external_data_in), .rf_RegWrite(rf_RegWrite),
    .rf_ALUSrc(rf_ALUSrc), .rf_ALUControl(rf_ALUControl), .rf_ALUResult(rf_ALUResult)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] aluRef(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      default: return a - b;
    endcase
  endfunction

  // Behavioural reg file and ALU that the controller steers.
  always_comb begin
    envB = rf_ALUSrc ? rf_external_data_in : envRf[rf_RA2];
    rf_ALUResult = aluRef(rf_ALUControl, envRf[rf_RA1], envB);
  end

  always @(posedge clk) begin
    if (rf_RegWrite) envRf[rf_WA] <= rf_ALUResult;
  end

  function automatic logic [15:0] mkInstr(input kind_e k, input logic [1:0] op,
                                          input logic [3:0] wa, input logic [3:0] ra1,
                                          input logic [3:0] ra2);
    instr_t t;
    t.kind = k; t.aluctl = op; t.wa = wa; t.ra1 = ra1; t.ra2 = ra2;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    assert (obs === exp) else begin
      miscompareCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one instruction, predicts its outcome from the golden registers,
  // optionally withholds res_ready for stallCycles, then retires it.
  task automatic applyStimulus(input logic [15:0] ins, input int stallCycles);
    instr_t      t;
    logic [7:0]  expRes;
    logic [3:0]  expWa;
    logic        wr;
    int          execCycles;
    int          pulses;
    t      = instr_t'(ins);
    wr     = (t.kind == K_LDI) || (t.kind == K_ALU);
    expRes = aluRef(t.aluctl, gold[t.ra1], (t.kind == K_LDI) ? {t.ra1, t.ra2} : gold[t.ra2]);
    expWa  = (t.kind == K_RD) ? t.ra1 : t.wa;

    if (t.kind == K_NOP) begin
      instr = ins; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      modelCount++;
      checkOutput("nop_retired", retired_count, modelCount);
      checkOutput("nop_res_valid", res_valid, 1'b0);
      checkOutput("nop_busy", busy, 1'b0);
      checkOutput("nop_regwrite", rf_RegWrite, 1'b0);
      return;
    end

    res_ready = (stallCycles == 0);
    instr = ins; instr_valid = 1'b1;
    checkOutput("instr_ready_idle", instr_ready, 1'b1);
    tick();
    // Junk offered while busy must be ignored.
    instr = 16'($urandom);
    execCycles = 0;
    pulses = 0;
    while (!res_valid && execCycles < 64) begin
      if (rf_RegWrite) pulses++;
      execCycles++;
      tick();
    end
    checkOutput("res_valid_rise", res_valid, 1'b1);
    checkOutput("settle_cycles", execCycles, SETTLE);
    checkOutput("regwrite_pulses", pulses, wr ? 1 : 0);
    checkOutput("res_data", res_data, expRes);
    checkOutput("res_wa", res_wa, expWa);
    if (wr) begin
      gold[t.wa] = expRes;
      checkOutput("rf_commit", envRf[t.wa], gold[t.wa]);
    end
    for (int i = 0; i < stallCycles; i++) begin
      tick();
      checkOutput("stall_res_valid", res_valid, 1'b1);
      checkOutput("stall_res_data", res_data, expRes);
      checkOutput("stall_instr_ready", instr_ready, 1'b0);
      checkOutput("stall_retired", retired_count, modelCount);
      checkOutput("stall_regwrite", rf_RegWrite, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    modelCount++;
    checkOutput("retire_count", retired_count, modelCount);
    checkOutput("retire_res_valid", res_valid, 1'b0);
    checkOutput("retire_busy", busy, 1'b0);
  endtask

  initial begin
    int nopBulk;

    // Reset state
    repeat (2) tick();
    checkOutput("rst_instr_ready", instr_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_retired", retired_count, 16'h0000);
    checkOutput("rst_regwrite", rf_RegWrite, 1'b0);
    checkOutput("rst_res_data", res_data, 8'h00);
    reset = 1'b1;
    tick();

    // Reset dropped mid-EXEC while the write enable is up
    applyStimulus(mkInstr(K_NOP, ALU_AND, 4'h0, 4'h0, 4'h0), 0);
    instr = mkInstr(K_LDI, ALU_ADD, 4'h5, 4'h3, 4'h3);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_rst_regwrite", rf_RegWrite, 1'b1);
    checkOutput("pre_rst_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midexec_regwrite", rf_RegWrite, 1'b0);
    checkOutput("midexec_busy", busy, 1'b0);
    checkOutput("midexec_res_valid", res_valid, 1'b0);
    checkOutput("midexec_retired", retired_count, 16'h0000);
    tick();
    checkOutput("midexec_reg_kept", envRf[5], 8'h00);
    checkOutput("midexec_still_idle", res_valid, 1'b0);
    reset = 1'b1;
    modelCount = '0;
    tick();

    // Immediate loads
    applyStimulus(mkInstr(K_LDI, ALU_ADD, 4'h5, 4'h0, 4'h5), 0);
    applyStimulus(mkInstr(K_LDI, ALU_ADD, 4'h4, 4'h0, 4'h4), 0);
    checkOutput("ldi_retired_two", retired_count, 16'h0002);

    // ALU add, then read back without a write
    applyStimulus(mkInstr(K_ALU, ALU_ADD, 4'h6, 4'h5, 4'h4), 0);
    checkOutput("add_reg6", envRf[6], 8'h09);
    applyStimulus(mkInstr(K_RD, ALU_OR, 4'hA, 4'h6, 4'h6), 0);
    checkOutput("rd_result", res_data, 8'h09);
    checkOutput("rd_no_write_regA", envRf[10], 8'h00);

    // Subtraction including 8-bit wrap
    applyStimulus(mkInstr(K_ALU, ALU_SUB, 4'h7, 4'h5, 4'h4), 0);
    checkOutput("sub_reg7", envRf[7], 8'h01);
    applyStimulus(mkInstr(K_ALU, ALU_SUB, 4'h8, 4'h4, 4'h5), 0);
    checkOutput("sub_wrap_reg8", envRf[8], 8'hFF);

    // Result backpressure
    applyStimulus(mkInstr(K_ALU, ALU_OR, 4'h9, 4'h5, 4'h4), 5);

    // Randomised traffic against the golden model
    for (int n = 0; n < 40; n++) begin
      applyStimulus(mkInstr(kind_e'(2'($urandom_range(0, 3))), 2'($urandom_range(0, 3)),
                            4'($urandom), 4'($urandom), 4'($urandom)),
                    $urandom_range(0, 3));
    end
    for (int r = 0; r < 16; r++) begin
      checkOutput($sformatf("final_reg%0d", r), envRf[r], gold[r]);
    end

    // Retire counter wrap via a long NOP stream
    nopBulk = int'(16'hFFFE - modelCount);
    instr = mkInstr(K_NOP, ALU_AND, 4'h0, 4'h0, 4'h0);
    instr_valid = 1'b1;
    repeat (nopBulk) tick();
    instr_valid = 1'b0;
    modelCount = 16'hFFFE;
    checkOutput("preload_fffe", retired_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mkInstr(K_NOP, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom)), 0);
    end
    checkOutput("wrap_to_one", retired_count, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
